// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader states and stream constants.
// LOADER_CHECKSUM_EN adds the CHECK state for the trailing checksum byte.
package imem_loader_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_BYTES = 4;
  localparam int MAX_WORDS = 128;
  localparam int LEN_ZERO_MEANS = 128;
  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: shifts bytes big-endian into a word and flags the completing byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         shift,
  input  logic [BYTE_W-1:0]            din,
  output logic [WORD_BYTES*BYTE_W-1:0] word_next,
  output logic                         word_full
);
  logic [WORD_BYTES*BYTE_W-1:0] word;
  logic [1:0] idx;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      idx <= '0;
    end else if (shift) begin
      word <= word_next;
      idx <= idx + 2'd1;
    end
  end
  assign word_next = {word[WORD_BYTES*BYTE_W-BYTE_W-1:0], din};
  assign word_full = shift && idx == 2'd3;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte stream to instruction-memory writes; holds the CPU until loaded.
// LOADER_CHECKSUM_EN enables a trailing 8-bit payload checksum byte.
module imem_loader #(
  parameter int ADDR_W = 7,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  import imem_loader_pkg::*;
  state_t state, nxt;
  logic acc, shift, full, last;
  logic [31:0] word_next;
  logic [ADDR_W:0] nwords, widx;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = S_CHECK;
  logic [7:0] cs;
  assign in_ready = state inside {S_LEN, S_DATA, S_CHECK};
`else
  localparam state_t AFTER_LAST = S_DONE;
  assign in_ready = state inside {S_LEN, S_DATA};
`endif
  assign acc = in_valid && in_ready;
  assign shift = acc && state == S_DATA;
  assign last = widx == nwords - 1'b1;
  assign wr_en = state == S_WRITE;
  assign done = state == S_DONE;
  assign error = state == S_ERR;
  assign cpu_hold = state != S_DONE;
  word_assembler u_asm (
    .clk(clk),
    .reset(reset),
    .clear(state == S_LEN),
    .shift(shift),
    .din(in_data),
    .word_next(word_next),
    .word_full(full)
  );
  always_ff @(posedge clk) state <= reset ? S_LEN : nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_LEN:   if (acc) nxt = int'(in_data) > MAX_WORDS ? S_ERR : S_DATA;
      S_DATA:  if (full) nxt = S_WRITE;
      S_WRITE: nxt = last ? AFTER_LAST : S_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (acc) nxt = in_data == cs ? S_DONE : S_ERR;
`endif
      S_DONE,
      S_ERR:   if (start) nxt = S_LEN;
      default: nxt = S_LEN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      nwords <= '0;
      widx <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (state == S_LEN && acc) begin
        nwords <= in_data == '0 ? (ADDR_W+1)'(LEN_ZERO_MEANS) : (ADDR_W+1)'(in_data);
        widx <= '0;
      end
      // latch on the completing byte so the word is stable throughout WRITE and after
      if (full) begin
        wr_addr <= widx[ADDR_W-1:0];
        wr_data <= word_next;
      end
      if (state == S_WRITE) widx <= widx + 1'b1;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || (state == S_LEN && acc)) cs <= '0;
    else if (shift) cs <= cs + in_data;
  end
`endif
endmodule
